tone_detector: RTL and testbench

Receive-side counterpart of the tone generator: samples a square-wave tone signal (the `speaker` waveform, looped back or from an external source), measures the period between rising edges in `clk` cycles, and classifies it against a 12-entry note table (C4..B4). It sits behind the tone generator in loopback tests and feeds the display/scoring logic with a period, a note index and a silence flag.

---
 rtl/tone_pkg.sv | 40 ++++
 rtl/tone_detector_edge_sync.sv | 24 ++
 rtl/tone_detector.sv | 139 +++++++++++++
 tb/tb_tone_detector.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared tone definitions: note table (C4..B4), "no note" code and the
// detector FSM encoding. The tone generator imports the same table so both
// ends agree on the exact period of every note.
package tone_pkg;

  localparam int unsigned NUM_NOTES      = 12;
  localparam logic [3:0]  NOTE_NONE      = 4'hF;
  localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;

  // Note frequencies in centi-hertz (two decimals), C4 first. Keeping them as
  // integers makes the rounded periods exact and identical in every tool.
  localparam int unsigned NOTE_FREQ_CHZ [NUM_NOTES] = '{
    26163, 27718, 29366, 31113, 32963, 34923,
    36999, 39200, 41530, 44000, 46616, 49388
  };

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } det_state_t;

  // round(clk_hz / f) in clock cycles for note idx
  function automatic int unsigned note_period(input longint unsigned clk_hz,
                                              input int idx);
    longint unsigned f_chz;
    f_chz = 64'(NOTE_FREQ_CHZ[idx]);
    return 32'((clk_hz * 64'd100 + f_chz / 64'd2) / f_chz);
  endfunction

  // Table at the default 100 MHz clock (C4=382219, A4=227273, B4=202478)
  localparam int unsigned NOTE_PERIOD [NUM_NOTES] = '{
    note_period(64'(CLK_HZ_DEFAULT), 0),  note_period(64'(CLK_HZ_DEFAULT), 1),
    note_period(64'(CLK_HZ_DEFAULT), 2),  note_period(64'(CLK_HZ_DEFAULT), 3),
    note_period(64'(CLK_HZ_DEFAULT), 4),  note_period(64'(CLK_HZ_DEFAULT), 5),
    note_period(64'(CLK_HZ_DEFAULT), 6),  note_period(64'(CLK_HZ_DEFAULT), 7),
    note_period(64'(CLK_HZ_DEFAULT), 8),  note_period(64'(CLK_HZ_DEFAULT), 9),
    note_period(64'(CLK_HZ_DEFAULT), 10), note_period(64'(CLK_HZ_DEFAULT), 11)
  };

endpackage

// File: rtl/tone_detector_edge_sync.sv
// Brings the asynchronous tone input into the clk domain and flags its rising
// edges. rise is a one-cycle strobe, valid two cycles after din goes high.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  // sync[0..1] form the metastability synchronizer, sync[2] is the delayed copy
  logic [2:0] sync;

  // Shift the input through the synchronizer and delay stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 3'b000;
    end else begin
      sync <= {sync[1:0], din};
    end
  end

  assign rise = sync[1] & ~sync[2];

endmodule

// File: rtl/tone_detector.sv
// Measures the rising-edge to rising-edge period of a square-wave tone in clk
// cycles and classifies it against the C4..B4 note table.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no tone tracked; counter parked at 0, waiting for an edge
// ST_MEASURE | counting cycles since the last accepted (or first) edge
module tone_detector
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int          CNT_W      = 20,
  parameter int unsigned TIMEOUT    = 1_048_575,
  parameter int unsigned MIN_PERIOD = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [3:0]       note,
  output logic             note_valid,
  output logic             silent
);

  // TIMEOUT must stay below 2**CNT_W so cnt + 1 never wraps.
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MIN_P      = CNT_W'(MIN_PERIOD);

  det_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             tone_edge;
  logic             accept;
  logic             timeout_hit;
  logic [NUM_NOTES-1:0] hit;
  logic [3:0]       note_next;

  edge_sync u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (tone_in),
    .rise (tone_edge)
  );

  assign cnt_inc = cnt + 1'b1;

  // An edge that closes a long-enough interval is a real period; an edge
  // landing on the timeout cycle still counts (edge wins over timeout).
  always_comb begin
    accept      = (state == ST_MEASURE) && tone_edge && (cnt_inc >= MIN_P);
    timeout_hit = (state == ST_MEASURE) && !accept && (cnt == TIMEOUT_M1);
  end

  // Measurement FSM: tracks the interval, publishes periods, declares silence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      silent       <= 1'b1;
    end else begin
      period_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt    <= '0;
          silent <= 1'b1;
          if (tone_edge) begin
            state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (accept) begin
            period       <= cnt_inc;
            period_valid <= 1'b1;
            cnt          <= '0;
            silent       <= 1'b0;
          end else if (timeout_hit) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            silent <= 1'b1;
          end else begin
            // Glitch edges (too short an interval) fall through here too.
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // One window comparator per note: |period - NP| <= NP/64, at CNT_W+1 bits
  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_note
    localparam int unsigned    NP_INT = note_period(64'(CLK_HZ), g);
    localparam logic [CNT_W:0] NP     = (CNT_W+1)'(NP_INT);
    localparam logic [CNT_W:0] TOL    = NP >> 6;

    logic [CNT_W:0] per_x;
    logic [CNT_W:0] diff;

    // Absolute distance between the measured period and this note
    always_comb begin
      per_x = {1'b0, period};
      diff  = (per_x >= NP) ? (per_x - NP) : (NP - per_x);
    end

    assign hit[g] = (diff <= TOL);
  end

  // Lowest matching note index wins; no match gives NOTE_NONE
  always_comb begin
    note_next = NOTE_NONE;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        note_next = 4'(i);
      end
    end
  end

  // Classifier register: one cycle behind period_valid, cleared on silence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note       <= NOTE_NONE;
      note_valid <= 1'b0;
    end else begin
      note_valid <= period_valid;
      if (period_valid) begin
        note <= note_next;
      end else if (timeout_hit) begin
        note <= NOTE_NONE;
      end
    end
  end

endmodule

// File: tb/tb_tone_detector.sv
// Randomized bench for tone_detector. The clock is scaled down to 400 kHz so
// real note periods (about 800..1530 cycles) fit a short run; the reference
// model works on rising-edge timestamps rather than counters.
module tb_tone_detector;

  localparam int unsigned CLK_HZ     = 400_000;
  localparam int          CNT_W      = 20;
  localparam int unsigned TIMEOUT    = 5000;
  localparam int unsigned MIN_PERIOD = 64;
  localparam int          LAT        = 3;   // tone_in drive to period_valid, in cycles

  localparam int FREQ_CHZ [12] = '{
    26163, 27718, 29366, 31113, 32963, 34923,
    36999, 39200, 41530, 44000, 46616, 49388
  };

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tone_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [3:0]       note;
  logic             note_valid;
  logic             silent;

  tone_detector #(
    .CLK_HZ     (CLK_HZ),
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .MIN_PERIOD (MIN_PERIOD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tone_in      (tone_in),
    .period       (period),
    .period_valid (period_valid),
    .note         (note),
    .note_valid   (note_valid),
    .silent       (silent)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int cyc = 0;
  bit h1, h2, h3, h4;           // tone_in driven 1..4 cycles ago
  bit tracking;
  int ref_cyc;                  // timestamp of last accepted / first edge
  int exp_period;
  bit exp_pv, exp_nv, exp_silent;
  int exp_note;
  bit pend;
  int pend_note;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int note_len(input int idx);
    longint f;
    f = longint'(FREQ_CHZ[idx]);
    return int'((longint'(CLK_HZ) * 100 + f / 2) / f);
  endfunction

  function automatic int classify(input int p);
    int np, d;
    for (int i = 0; i < 12; i++) begin
      np = note_len(i);
      d  = (p > np) ? p - np : np - p;
      if (d <= np / 64) return i;
    end
    return 15;
  endfunction

  task automatic model_reset();
    tracking   = 1'b0;
    exp_period = 0;
    exp_silent = 1'b1;
    exp_note   = 15;
    exp_pv     = 1'b0;
    exp_nv     = 1'b0;
    pend       = 1'b0;
    {h1, h2, h3, h4} = 4'b0000;
  endtask

  task automatic check_all();
    check_eq("period_valid", 32'(period_valid), 32'(exp_pv));
    check_eq("note_valid",   32'(note_valid),   32'(exp_nv));
    check_eq("silent",       32'(silent),       32'(exp_silent));
    check_eq("period",       32'(period),       exp_period);
    check_eq("note",         32'(note),         exp_note);
  endtask

  // One clock: check outputs at the falling edge, then drive the next input.
  task automatic tick(input bit v);
    bit rise;
    int age;
    @(negedge clk);
    if (rst) begin
      model_reset();
    end else begin
      exp_pv = 1'b0;
      exp_nv = 1'b0;
      if (pend) begin
        exp_nv   = 1'b1;
        exp_note = pend_note;
        pend     = 1'b0;
      end
      rise = h3 && !h4;
      if (tracking) begin
        age = (cyc - LAT) - ref_cyc;
        if (rise && age >= int'(MIN_PERIOD)) begin
          exp_pv     = 1'b1;
          exp_period = age;
          exp_silent = 1'b0;
          pend       = 1'b1;
          pend_note  = classify(age);
          ref_cyc    = cyc - LAT;
        end else if (!rise && age == int'(TIMEOUT)) begin
          tracking   = 1'b0;
          exp_silent = 1'b1;
          exp_note   = 15;
        end
      end else if (rise) begin
        tracking = 1'b1;
        ref_cyc  = cyc - LAT;
      end
    end
    check_all();
    tone_in = v;
    {h4, h3, h2, h1} = {h3, h2, h1, v};
    if (rst) {h1, h2, h3, h4} = 4'b0000;
    cyc++;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  // One tone cycle of len clocks starting with a rising edge, random duty
  task automatic rand_wave(input int len);
    int hi;
    hi = 2 + int'($urandom_range(0, len - 4));
    for (int i = 0; i < len; i++) tick(i < hi);
  endtask

  // 1000-cycle tone cycle with a 10-cycle glitch pulse shortly after the edge
  task automatic glitch_wave();
    int hi;
    hi = int'($urandom_range(3, 15));
    for (int i = 0; i < 1000; i++)
      tick((i < hi) || (i >= hi + 5 && i < hi + 15));
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before the next clock.
  task automatic async_reset(input int hold);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < hold; i++) tick(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int a4;
    int offs [7];
    model_reset();
    offs = '{0, 0, 12, 16, -14, -15, 14};

    repeat (4) tick(1'b0);
    rst = 1'b0;
    quiet(100);

    // steady 1000-cycle tone, then glitch rejection
    repeat (5) rand_wave(1000);
    glitch_wave();
    repeat (2) rand_wave(1000);

    // silence after the tone stops, then restart from idle
    quiet(TIMEOUT + 200);
    repeat (3) rand_wave(1000);

    // interval exactly TIMEOUT (edge wins) and one beyond it
    rand_wave(TIMEOUT);
    rand_wave(1000);
    rand_wave(TIMEOUT + 1);
    repeat (2) rand_wave(1000);

    // MIN_PERIOD boundary
    rand_wave(MIN_PERIOD - 1);
    rand_wave(300);
    rand_wave(MIN_PERIOD);
    rand_wave(MIN_PERIOD + 1);

    // A4 and its tolerance window
    a4 = note_len(9);
    foreach (offs[i]) rand_wave(a4 + offs[i]);

    // random notes with random detuning
    repeat (6) begin
      rand_wave(note_len(int'($urandom_range(0, 11))) + int'($urandom_range(0, 50)) - 25);
    end

    // random short intervals straddling MIN_PERIOD
    repeat (20) rand_wave(int'($urandom_range(40, 200)));

    // reset in the middle of a measurement, then recover
    rand_wave(1000);
    for (int i = 0; i < 400; i++) tick(i < 200);
    async_reset(3);
    quiet(20);
    repeat (3) rand_wave(1000);

    quiet(TIMEOUT + 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
